// File: rtl/trigger_out_capture.sv
// Sticky trigger collector with host snapshot/read; optional rising-edge event
// detection enabled by defining TRIGGER_EDGE_DETECT_EN.
module trigger_out_capture #(
    parameter int unsigned WIDTH   = 16,
    parameter logic [7:0]  EP_ADDR = 8'h60
) (
    input  logic             ti_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ep_trigger,
    input  logic [7:0]       host_addr,
    input  logic             host_update,
    input  logic             host_read,
    output logic [15:0]      host_data,
    output logic             host_data_valid,
    output logic             pending,
    output logic             overrun
);

    typedef enum logic {StIdle, StHeld} state_t;

    state_t           state;
    logic [WIDTH-1:0] sticky;
    logic [WIDTH-1:0] snap;
    logic [WIDTH-1:0] events;
    logic [WIDTH-1:0] sticky_next;
    logic [15:0]      snap_ext;
    logic             upd;
    logic             rd;

    assign upd = host_update && (host_addr == EP_ADDR);
    assign rd  = host_read && (host_addr == EP_ADDR);

`ifdef TRIGGER_EDGE_DETECT_EN
    logic [WIDTH-1:0] prev;

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= ep_trigger;
        end
    end

    assign events = ep_trigger & ~prev;
`else
    assign events = ep_trigger;
`endif

    // Same-cycle events are folded into the snapshot, so clearing on update loses nothing.
    assign sticky_next = upd ? '0 : (sticky | events);

    always_comb begin
        snap_ext            = '0;
        snap_ext[WIDTH-1:0] = snap;
    end

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            state           <= StIdle;
            sticky          <= '0;
            snap            <= '0;
            host_data       <= '0;
            host_data_valid <= 1'b0;
            pending         <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            sticky          <= sticky_next;
            pending         <= |sticky_next;
            host_data_valid <= rd;
            if (rd) begin
                host_data <= (state == StHeld) ? snap_ext : 16'h0000;
            end

            if (rd && upd) begin
                // Read returns the old snapshot, then the update starts a fresh one.
                snap    <= sticky | events;
                overrun <= 1'b0;
                state   <= StHeld;
            end else if (upd) begin
                if (state == StIdle) begin
                    snap <= sticky | events;
                end else begin
                    snap    <= snap | sticky | events;
                    overrun <= 1'b1;
                end
                state <= StHeld;
            end else if (rd && (state == StHeld)) begin
                snap    <= '0;
                overrun <= 1'b0;
                state   <= StIdle;
            end
        end
    end

endmodule

// File: tb/tb_trigger_out_capture.sv
// Directed bench for trigger_out_capture; read results are scoreboarded through a queue.
module tb_trigger_out_capture;

    localparam logic [7:0] EP  = 8'h60;
    localparam logic [7:0] BAD = 8'h61;

    logic        ti_clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ep_trigger = '0;
    logic [7:0]  host_addr = EP;
    logic        host_update = 1'b0;
    logic        host_read = 1'b0;
    logic [15:0] host_data;
    logic        host_data_valid;
    logic        pending;
    logic        overrun;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_q[$];

    trigger_out_capture #(
        .WIDTH   (16),
        .EP_ADDR (EP)
    ) dut (
        .ti_clk          (ti_clk),
        .reset           (reset),
        .ep_trigger      (ep_trigger),
        .host_addr       (host_addr),
        .host_update     (host_update),
        .host_read       (host_read),
        .host_data       (host_data),
        .host_data_valid (host_data_valid),
        .pending         (pending),
        .overrun         (overrun)
    );

    always #5 ti_clk = ~ti_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, then check the read channel against the scoreboard.
    task automatic step(input logic [15:0] trig, input logic [7:0] addr, input logic upd,
                        input logic rd, input logic [15:0] exp_rd);
        logic [15:0] e;
        ep_trigger  = trig;
        host_addr   = addr;
        host_update = upd;
        host_read   = rd;
        if (rd && (addr == EP) && !reset) exp_q.push_back(exp_rd);
        @(posedge ti_clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("valid_pulse", {15'd0, host_data_valid}, 16'd1);
            chk("read_data", host_data, e);
        end else begin
            chk("no_valid", {15'd0, host_data_valid}, 16'd0);
        end
    endtask

    task automatic idle();
        step(16'h0000, EP, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        step(16'h00ff, EP, 1'b1, 1'b0, 16'h0000);
        reset = 1'b0;
        idle();
        chk("rst_data", host_data, 16'h0000);
        chk("rst_pending", {15'd0, pending}, 16'd0);
        chk("rst_overrun", {15'd0, overrun}, 16'd0);

        // Read while idle returns zero
        step(16'h0000, EP, 1'b0, 1'b1, 16'h0000);
        chk("idle_rd_pending", {15'd0, pending}, 16'd0);

        // Two separated events accumulate
        step(16'h0001, EP, 1'b0, 1'b0, 16'h0000);
        chk("pending_set", {15'd0, pending}, 16'd1);
        idle();
        step(16'h0002, EP, 1'b0, 1'b0, 16'h0000);
        idle();
        step(16'h0000, EP, 1'b1, 1'b0, 16'h0000);
        chk("pending_clr", {15'd0, pending}, 16'd0);
        step(16'h0000, EP, 1'b0, 1'b1, 16'h0003);
        step(16'h0000, EP, 1'b0, 1'b1, 16'h0000);
        idle();
        chk("data_hold", host_data, 16'h0000);

        // Event in the same cycle as the update lands in the snapshot
        step(16'h0004, EP, 1'b1, 1'b0, 16'h0000);
        chk("same_cyc_pending", {15'd0, pending}, 16'd0);
        step(16'h0000, EP, 1'b0, 1'b1, 16'h0004);
        chk("same_cyc_overrun", {15'd0, overrun}, 16'd0);

        // Overrun: second update merges into unread snapshot
        step(16'h0001, EP, 1'b0, 1'b0, 16'h0000);
        step(16'h0000, EP, 1'b1, 1'b0, 16'h0000);
        chk("ovr_before", {15'd0, overrun}, 16'd0);
        step(16'h0080, EP, 1'b0, 1'b0, 16'h0000);
        step(16'h0000, EP, 1'b1, 1'b0, 16'h0000);
        chk("ovr_set", {15'd0, overrun}, 16'd1);
        step(16'h0000, EP, 1'b0, 1'b1, 16'h0081);
        chk("ovr_clr", {15'd0, overrun}, 16'd0);

        // Simultaneous read and update while held
        step(16'h0001, EP, 1'b0, 1'b0, 16'h0000);
        step(16'h0000, EP, 1'b1, 1'b0, 16'h0000);
        step(16'h0010, EP, 1'b0, 1'b0, 16'h0000);
        chk("rdupd_pending", {15'd0, pending}, 16'd1);
        step(16'h0000, EP, 1'b1, 1'b1, 16'h0001);
        chk("rdupd_overrun", {15'd0, overrun}, 16'd0);
        step(16'h0000, EP, 1'b0, 1'b1, 16'h0010);

        // Foreign address: strobes ignored, events still collected
        step(16'h0008, BAD, 1'b1, 1'b0, 16'h0000);
        chk("bad_upd_pending", {15'd0, pending}, 16'd1);
        step(16'h0000, BAD, 1'b0, 1'b1, 16'h0000);
        chk("bad_rd_hold", host_data, 16'h0010);
        step(16'h0000, EP, 1'b1, 1'b0, 16'h0000);
        step(16'h0000, EP, 1'b0, 1'b1, 16'h0008);

        // Reset overrides a simultaneous update
        step(16'h0020, EP, 1'b0, 1'b0, 16'h0000);
        step(16'h0000, EP, 1'b1, 1'b0, 16'h0000);
        reset = 1'b1;
        step(16'h0040, EP, 1'b1, 1'b0, 16'h0000);
        reset = 1'b0;
        chk("rst2_pending", {15'd0, pending}, 16'd0);
        chk("rst2_data", host_data, 16'h0000);
        step(16'h0000, EP, 1'b1, 1'b0, 16'h0000);
        chk("rst2_overrun", {15'd0, overrun}, 16'd0);
        step(16'h0000, EP, 1'b0, 1'b1, 16'h0000);

`ifdef TRIGGER_EDGE_DETECT_EN
        // Held level produces a single event
        for (int i = 0; i < 10; i++) step(16'h0001, EP, 1'b0, 1'b0, 16'h0000);
        step(16'h0001, EP, 1'b1, 1'b0, 16'h0000);
        step(16'h0001, EP, 1'b0, 1'b1, 16'h0001);
        step(16'h0001, EP, 1'b1, 1'b0, 16'h0000);
        step(16'h0001, EP, 1'b0, 1'b1, 16'h0000);
`else
        // Held level counts every cycle, so it reappears after each update
        for (int i = 0; i < 10; i++) step(16'h0001, EP, 1'b0, 1'b0, 16'h0000);
        step(16'h0001, EP, 1'b1, 1'b0, 16'h0000);
        step(16'h0001, EP, 1'b0, 1'b1, 16'h0001);
        step(16'h0001, EP, 1'b1, 1'b0, 16'h0000);
        step(16'h0000, EP, 1'b0, 1'b1, 16'h0001);
`endif
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
